// File: rtl/timer_pkg.sv
// Shared types and default constants for the millisecond tick timer.
// The optional TIMER_STICKY_EN build adds sticky expiry flags in ms_tick_timer.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } chan_state_t;

   localparam int CLK_FREQ_HZ = 100_000_000;
   localparam int TICK_HZ     = 1000;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV prescaler producing the timebase strobe.
// The strobe is combinational so it lines up with the terminal count cycle.
module tick_prescaler #(
   parameter int DIV = 100_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic ms_tick
);

   localparam int CW = $clog2(DIV);

   if (DIV < 2) begin : g_div_check
      $error("tick_prescaler: DIV must be at least 2");
   end

   logic [CW-1:0] cnt_reg;
   logic          last;

   assign last    = (cnt_reg == CW'(DIV - 1));
   assign ms_tick = en && last;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_reg <= '0;
      end else if (en) begin
         cnt_reg <= last ? '0 : cnt_reg + CW'(1);
      end
   end

endmodule

// File: rtl/ms_tick_timer.sv
// Multi-channel millisecond timer: one shared prescaler, NCH one-shot/periodic channels.
// Define TIMER_STICKY_EN to add the clr inputs and sticky expired flags.
module ms_tick_timer #(
   parameter int CLK_FREQ_HZ = timer_pkg::CLK_FREQ_HZ,
   parameter int TICK_HZ     = timer_pkg::TICK_HZ,
   parameter int NCH         = 4,
   parameter int DW          = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [NCH-1:0]         start,
   input  logic [NCH-1:0]         stop,
   input  logic [NCH-1:0]         periodic,
   input  logic [NCH-1:0][DW-1:0] delay_ms,
`ifdef TIMER_STICKY_EN
   input  logic [NCH-1:0]         clr,
`endif
   output logic                   ms_tick,
   output logic [NCH-1:0]         tic,
   output logic [NCH-1:0]         busy,
   output logic [NCH-1:0][DW-1:0] count
`ifdef TIMER_STICKY_EN
   ,
   output logic [NCH-1:0]         expired
`endif
);

   import timer_pkg::*;

   localparam int DIV = CLK_FREQ_HZ / TICK_HZ;

   logic tick;

   tick_prescaler #(
      .DIV (DIV)
   ) u_prescaler (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .ms_tick (tick)
   );

   assign ms_tick = tick;

   for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      chan_state_t   state_reg;
      chan_state_t   state_next;
      logic [DW-1:0] count_reg;
      logic [DW-1:0] delay_reg;
      logic          periodic_reg;
      logic          tic_reg;
      logic          advance;
      logic          expire;

      // tick already carries en, so a disabled timer never advances
      assign advance = (state_reg == RUN) && tick;
      assign expire  = advance && ((count_reg + DW'(1)) == delay_reg);

      always_ff @(posedge clk) begin
         if (!rst) begin
            state_reg <= IDLE;
         end else begin
            state_reg <= state_next;
         end
      end

      always_comb begin
         state_next = state_reg;
         if (start[gi]) begin
            state_next = (delay_ms[gi] == '0) ? DONE : RUN;
         end else if (stop[gi]) begin
            state_next = IDLE;
         end else if (expire && !periodic_reg) begin
            state_next = DONE;
         end
      end

      always_comb begin
         busy[gi] = (state_reg == RUN);
      end

      // start outranks stop, and stop outranks an expiry landing on the same edge
      always_ff @(posedge clk) begin
         if (!rst) begin
            count_reg    <= '0;
            delay_reg    <= '0;
            periodic_reg <= 1'b0;
            tic_reg      <= 1'b0;
         end else begin
            tic_reg <= 1'b0;
            if (start[gi]) begin
               delay_reg    <= delay_ms[gi];
               periodic_reg <= periodic[gi];
               count_reg    <= '0;
               tic_reg      <= (delay_ms[gi] == '0);
            end else if (stop[gi]) begin
               count_reg <= '0;
            end else if (expire) begin
               tic_reg   <= 1'b1;
               count_reg <= periodic_reg ? '0 : delay_reg;
            end else if (advance) begin
               count_reg <= count_reg + DW'(1);
            end
         end
      end

      assign tic[gi]   = tic_reg;
      assign count[gi] = count_reg;

`ifdef TIMER_STICKY_EN
      logic expired_reg;

      always_ff @(posedge clk) begin
         if (!rst) begin
            expired_reg <= 1'b0;
         end else if (tic_reg) begin
            expired_reg <= 1'b1;
         end else if (clr[gi]) begin
            expired_reg <= 1'b0;
         end
      end

      assign expired[gi] = expired_reg;
`endif
   end

endmodule

// File: tb/tb_ms_tick_timer.sv
// Directed self-checking bench for ms_tick_timer with DIV=10, NCH=2, DW=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ms_tick_timer;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            en = 1'b0;
   logic [1:0]      start = '0;
   logic [1:0]      stop = '0;
   logic [1:0]      periodic = '0;
   logic [1:0][7:0] delay_ms = '0;
   logic            ms_tick;
   logic [1:0]      tic;
   logic [1:0]      busy;
   logic [1:0][7:0] count;
`ifdef TIMER_STICKY_EN
   logic [1:0]      clr = '0;
   logic [1:0]      expired;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ms_tick_timer #(
      .CLK_FREQ_HZ (1000),
      .TICK_HZ     (100),
      .NCH         (2),
      .DW          (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .start    (start),
      .stop     (stop),
      .periodic (periodic),
      .delay_ms (delay_ms),
`ifdef TIMER_STICKY_EN
      .clr      (clr),
`endif
      .ms_tick  (ms_tick),
      .tic      (tic),
      .busy     (busy),
      .count    (count)
`ifdef TIMER_STICKY_EN
      ,
      .expired  (expired)
`endif
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Leaves the bench on a falling edge where ms_tick is high (prescaler at DIV-1).
   task automatic wait_tick();
      bit seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         step();
         seen = ms_tick;
      end
      vectors++;
      if (seen !== 1'b1) begin
         miscompares++;
         $display("FAIL wait_tick: got no ms_tick within 30 cycles, required one");
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      en  = 1'b1;
      step(); step(); step();
      vectors++;
      if ({ms_tick, tic, busy, count} !== 21'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h required 0", {ms_tick, tic, busy, count});
      end
      rst = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         vectors++;
         if (ms_tick !== (k == 9)) begin
            miscompares++;
            $display("FAIL reset_prescaler k=%0d: ms_tick got %b required %b", k, ms_tick, (k == 9));
         end
      end
      $display("reset: prescaler first tick checked");
   endtask

   task automatic test_oneshot();
      logic [7:0] exp_count;
      wait_tick();
      start[0] = 1'b1; delay_ms[0] = 8'd3; periodic[0] = 1'b0;
      for (int k = 1; k <= 33; k++) begin
         step();
         if (k == 1) start[0] = 1'b0;
         exp_count = (k >= 31) ? 8'd3 : (k >= 21) ? 8'd2 : (k >= 11) ? 8'd1 : 8'd0;
         vectors += 3;
         if (tic[0] !== (k == 31)) begin
            miscompares++;
            $display("FAIL oneshot_tic k=%0d: got %b required %b", k, tic[0], (k == 31));
         end
         if (busy[0] !== (k < 31)) begin
            miscompares++;
            $display("FAIL oneshot_busy k=%0d: got %b required %b", k, busy[0], (k < 31));
         end
         if (count[0] !== exp_count) begin
            miscompares++;
            $display("FAIL oneshot_count k=%0d: got %0d required %0d", k, count[0], exp_count);
         end
      end
      $display("oneshot: delay=3 on channel 0 checked");
   endtask

   task automatic test_periodic();
      logic [7:0] exp_count;
      logic       exp_tic;
      wait_tick();
      start[1] = 1'b1; delay_ms[1] = 8'd2; periodic[1] = 1'b1;
      for (int k = 1; k <= 101; k++) begin
         step();
         if (k == 1) start[1] = 1'b0;
         exp_count = 8'(((k - 1) / 10) % 2);
         exp_tic   = (k > 1) && (k % 20 == 1);
         vectors += 3;
         if (tic[1] !== exp_tic) begin
            miscompares++;
            $display("FAIL periodic_tic k=%0d: got %b required %b", k, tic[1], exp_tic);
         end
         if (count[1] !== exp_count) begin
            miscompares++;
            $display("FAIL periodic_count k=%0d: got %0d required %0d", k, count[1], exp_count);
         end
         if (busy[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL periodic_busy k=%0d: got %b required 1", k, busy[1]);
         end
      end
      stop[1] = 1'b1;
      step();
      stop[1] = 1'b0;
      vectors++;
      if ({busy[1], count[1], tic[1]} !== 10'd0) begin
         miscompares++;
         $display("FAIL periodic_stop: got busy=%b count=%0d tic=%b required all 0", busy[1], count[1], tic[1]);
      end
      $display("periodic: delay=2 on channel 1 over 5 periods checked");
   endtask

   task automatic test_restart_stop();
      logic [7:0] exp_count;
      // restart at count=2 of a delay-4 one-shot
      wait_tick();
      start[0] = 1'b1; delay_ms[0] = 8'd4; periodic[0] = 1'b0;
      for (int k = 1; k <= 63; k++) begin
         step();
         if (k == 1 || k == 22) start[0] = 1'b0;
         if (k <= 21) exp_count = (k >= 21) ? 8'd2 : (k >= 11) ? 8'd1 : 8'd0;
         else exp_count = (k >= 61) ? 8'd4 : (k >= 51) ? 8'd3 : (k >= 41) ? 8'd2 : (k >= 31) ? 8'd1 : 8'd0;
         vectors += 2;
         if (tic[0] !== (k == 61)) begin
            miscompares++;
            $display("FAIL restart_tic k=%0d: got %b required %b", k, tic[0], (k == 61));
         end
         if (count[0] !== exp_count) begin
            miscompares++;
            $display("FAIL restart_count k=%0d: got %0d required %0d", k, count[0], exp_count);
         end
         if (k == 21) start[0] = 1'b1;
      end
      $display("restart: channel 0 restarted at count=2 checked");

      // start+stop together runs; a lone stop on the expiry edge swallows the tic
      wait_tick();
      start[0] = 1'b1; stop[0] = 1'b1; delay_ms[0] = 8'd2; periodic[0] = 1'b0;
      for (int k = 1; k <= 22; k++) begin
         step();
         if (k == 1) begin start[0] = 1'b0; stop[0] = 1'b0; end
         if (k == 21) stop[0] = 1'b0;
         vectors += 3;
         if (tic[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_tic k=%0d: got %b required 0", k, tic[0]);
         end
         if (busy[0] !== (k <= 20)) begin
            miscompares++;
            $display("FAIL stop_busy k=%0d: got %b required %b", k, busy[0], (k <= 20));
         end
         exp_count = (k <= 20 && k >= 11) ? 8'd1 : 8'd0;
         if (count[0] !== exp_count) begin
            miscompares++;
            $display("FAIL stop_count k=%0d: got %0d required %0d", k, count[0], exp_count);
         end
         if (k == 20) stop[0] = 1'b1;
      end
      $display("stop: start+stop and stop-at-expiry checked");
   endtask

   task automatic test_enable();
      logic [7:0] exp_count;
      wait_tick();
      start[1] = 1'b1; delay_ms[1] = 8'd3; periodic[1] = 1'b0;
      for (int k = 1; k <= 58; k++) begin
         step();
         if (k == 1) start[1] = 1'b0;
         exp_count = (k >= 56) ? 8'd3 : (k >= 46) ? 8'd2 : (k >= 36) ? 8'd1 : 8'd0;
         vectors += 3;
         if (tic[1] !== (k == 56)) begin
            miscompares++;
            $display("FAIL enable_tic k=%0d: got %b required %b", k, tic[1], (k == 56));
         end
         if (busy[1] !== (k < 56)) begin
            miscompares++;
            $display("FAIL enable_busy k=%0d: got %b required %b", k, busy[1], (k < 56));
         end
         if (count[1] !== exp_count) begin
            miscompares++;
            $display("FAIL enable_count k=%0d: got %0d required %0d", k, count[1], exp_count);
         end
         if (k == 6)  en = 1'b0;
         if (k == 31) en = 1'b1;
      end
      $display("enable: 25-cycle freeze on channel 1 checked");
   endtask

   task automatic test_zero_delay();
      start[0] = 1'b1; delay_ms[0] = 8'd0; periodic[0] = 1'b1;
      step();
      start[0] = 1'b0;
      vectors++;
      if ({tic[0], busy[0], count[0]} !== 10'b10_0000_0000) begin
         miscompares++;
         $display("FAIL zero_delay_first: got tic=%b busy=%b count=%0d required 1,0,0", tic[0], busy[0], count[0]);
      end
      step();
      vectors++;
      if ({tic[0], busy[0]} !== 2'b00) begin
         miscompares++;
         $display("FAIL zero_delay_after: got tic=%b busy=%b required 0,0", tic[0], busy[0]);
      end
      $display("zero_delay: immediate tic and DONE checked");
   endtask

   task automatic test_reset_midrun();
      wait_tick();
      start[0] = 1'b1; delay_ms[0] = 8'd3; periodic[0] = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k == 1) start[0] = 1'b0;
      end
      vectors++;
      if (count[0] !== 8'd1) begin
         miscompares++;
         $display("FAIL midrun_count_before: got %0d required 1", count[0]);
      end
      rst = 1'b0;
      step();
      vectors++;
      if ({ms_tick, tic, busy, count} !== 21'd0) begin
         miscompares++;
         $display("FAIL midrun_reset: got %h required 0", {ms_tick, tic, busy, count});
      end
      rst = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         step();
         vectors++;
         if ({tic, busy} !== 4'd0) begin
            miscompares++;
            $display("FAIL midrun_after k=%0d: got tic=%b busy=%b required 0", k, tic, busy);
         end
      end
      $display("reset_midrun: abort without tic checked");
   endtask

`ifdef TIMER_STICKY_EN
   task automatic test_sticky();
      start[0] = 1'b1; delay_ms[0] = 8'd0; periodic[0] = 1'b0;
      step();
      start[0] = 1'b0;
      clr[0]   = 1'b1;
      step();
      vectors++;
      if (expired[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL sticky_collision: got %b required 1", expired[0]);
      end
      step();
      clr[0] = 1'b0;
      vectors++;
      if (expired[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL sticky_clear: got %b required 0", expired[0]);
      end
      $display("sticky: set-wins and clear checked");
   endtask
`endif

   initial begin
      test_reset();
      test_oneshot();
      test_periodic();
      test_restart_stop();
      test_enable();
      test_zero_delay();
      test_reset_midrun();
`ifdef TIMER_STICKY_EN
      test_sticky();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ms_tick_timer.md
MS_TICK_TIMER -- requirements
Module: ms_tick_timer

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100_000_000, is the input clock frequency.
REQ-002 Parameter TICK_HZ, default 1000, is the timebase tick rate (1 ms).
REQ-003 Parameter NCH, default 4, is the number of independent timer channels.
REQ-004 Parameter DW, default 16, is the width of the delay and count fields.
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 en  in  1  global enable; low freezes prescaler and all channels.
REQ-008 start  in  NCH  per-channel start pulse; latches delay_ms and (re)starts the channel.
REQ-009 stop  in  NCH  per-channel stop pulse; returns the channel to IDLE.
REQ-010 periodic  in  NCH  mode sampled at start: 1 = auto-reload, 0 = one-shot.
REQ-011 delay_ms  in  NCH x DW  delay in ticks, sampled at start.
REQ-012 ms_tick  out  1  one-cycle timebase pulse.
REQ-013 tic  out  NCH  one-cycle expiry pulse per channel.
REQ-014 busy  out  NCH  high while the channel is in RUN.
REQ-015 count  out  NCH x DW  elapsed ticks since the last start or reload.

Function
REQ-016 The prescaler SHALL count 0..DIV-1, where DIV = CLK_FREQ_HZ/TICK_HZ (elaboration error if DIV < 2); ms_tick is high in the cycle the count equals DIV-1 and en=1.
REQ-017 Each channel SHALL run FSM IDLE -> RUN -> DONE; DONE -> RUN on start; RUN or DONE -> IDLE on stop.
REQ-018 On start, the channel SHALL latch delay_ms and periodic, clear count to 0, and enter RUN on the next edge.
REQ-019 In RUN, on ms_tick, count SHALL increment; when count+1 equals the latched delay, tic SHALL be registered high for exactly the next cycle.
REQ-020 At expiry in periodic mode, count SHALL reload to 0 and the channel stays in RUN, with no lost or extra tick.
REQ-021 At expiry in one-shot mode, count SHALL hold the latched delay and the channel enters DONE (busy=0).
REQ-022 start with delay_ms=0 SHALL pulse tic on the next cycle and enter DONE regardless of periodic.
REQ-023 start while in RUN SHALL restart the channel; start and stop in the same cycle SHALL resolve to start.
REQ-024 stop SHALL clear count to 0 and suppress any tic due in that cycle.
REQ-025 en=0 SHALL hold the prescaler, count and FSM state; start and stop are still accepted.
REQ-026 Arithmetic SHALL be unsigned DW-bit; count never wraps because expiry fires at or before 2^DW-1.

Reset
REQ-027 With rst=0 at a rising edge: prescaler=0, all channels IDLE, count=0, latched delay=0, and ms_tick, tic and busy all 0.
REQ-028 Reset mid-run SHALL abort all channels with no tic emitted.

Configuration
REQ-029 With macro TIMER_STICKY_EN defined, ports clr (in, NCH) and expired (out, NCH) SHALL exist; expired[i] sets on tic[i] and clears on clr[i], set wins on collision, and resets to 0.
REQ-030 Without TIMER_STICKY_EN defined, clr and expired SHALL be absent and all other behaviour is identical.

Structure
REQ-031 Package timer_pkg SHALL hold the chan_state_t enum (IDLE, RUN, DONE) and the default constants CLK_FREQ_HZ and TICK_HZ.
REQ-032 The prescaler SHALL be a sub-module, tick_prescaler, instanced once; the channels are a generate loop in ms_tick_timer.

Verification (CLK_FREQ_HZ=1000, TICK_HZ=100, DIV=10, NCH=2, DW=8)
REQ-033 One-shot: start[0], delay=3, periodic=0 -> tic[0] once, 1 cycle after the third ms_tick; busy[0] falls; count[0]=3.
REQ-034 Periodic: start[1], delay=2, periodic=1 -> tic[1] every 20 clocks over 5 periods; count cycles 0,1,0,1.
REQ-035 Restart/stop: restart at count=2 of delay=4 -> tic after 4 further ticks; stop and start same cycle -> RUN; stop alone at an expiry edge -> no tic.
REQ-036 en low for 25 cycles mid-run -> expiry delayed by exactly 25 cycles; delay=0 start -> tic next cycle, DONE.
REQ-037 rst low at count=1 -> all outputs 0 next edge, no tic; with TIMER_STICKY_EN, clr coinciding with tic -> expired=1.
